// File: rtl/uart_rx_oversample_if.sv
// uart_rx_oversample_if
// Byte/strobe bus between the UART receive front end and the rx FIFO write port.
//   data       : received byte (rx FIFO din), held until the next valid
//   valid      : 1-cycle write strobe (rx FIFO wr_en)
//   frame_err  : 1-cycle strobe, stop bit sampled low
//   parity_err : 1-cycle strobe, parity mismatch
//   brk        : 1-cycle strobe, break (all bits low), together with frame_err
//   overrun    : 1-cycle strobe, good byte dropped because the FIFO was full
//   fifo_full  : rx FIFO full flag
// master = receiver side, slave = FIFO side.
interface uart_rx_oversample_if;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       brk;
    logic       overrun;
    logic       fifo_full;

    modport master (
        output data, valid, frame_err, parity_err, brk, overrun,
        input  fifo_full
    );

    modport slave (
        input  data, valid, frame_err, parity_err, brk, overrun,
        output fifo_full
    );
endinterface

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample
// UART receive front end: synchronises rx_i, detects the start edge, votes each bit
// 2-of-3 around mid-period, deserialises LSB-first with optional parity and emits
// single-cycle write/error strobes towards the rx FIFO.
// Ports:
//   clk_i       : system clock
//   rst_ni      : synchronous active-low reset
//   baud_div_i  : clocks per bit (values < 4 act as 4), latched on the start edge
//   rx_i        : asynchronous serial input, idle high
//   busy_o      : high whenever the receiver is not idle
//   rx_bus      : byte/strobe bus to the rx FIFO (master side)
module uart_rx_oversample #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_BITS   = 8,
    parameter bit          PARITY_EN   = 1'b0,
    parameter bit          PARITY_ODD  = 1'b0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [15:0]                 baud_div_i,
    input  logic                        rx_i,
    output logic                        busy_o,
    uart_rx_oversample_if.master        rx_bus
);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StWaitIdle
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs_prev_q;
    logic [15:0]            cnt_q;
    logic [15:0]            n_q;
    logic [3:0]             k_q;
    logic                   s1_q, s2_q;
    logic [7:0]             shreg_q;
    logic                   perr_q;
    logic                   zero_q;

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       frame_err_q, frame_err_d;
    logic       parity_err_q, parity_err_d;
    logic       brk_q, brk_d;
    logic       overrun_q, overrun_d;

    logic        rxs, edge_det, vote, par_calc, last_data;
    logic        is_s1, is_s2, is_vote;
    logic [15:0] half, baud_clamped;
    logic [2:0]  bit_idx;

    assign rxs          = sync_q[SYNC_STAGES-1];
    assign edge_det     = ~rxs & rxs_prev_q;
    assign baud_clamped = (baud_div_i < 16'd4) ? 16'd4 : baud_div_i;
    assign half         = n_q >> 1;
    assign is_s1        = (cnt_q == half - 16'd1);
    assign is_s2        = (cnt_q == half);
    assign is_vote      = (cnt_q == half + 16'd1);
    // Third sample is taken live on the vote cycle.
    assign vote         = (s1_q & s2_q) | (s1_q & rxs) | (s2_q & rxs);
    assign last_data    = (k_q == 4'(DATA_BITS));
    assign bit_idx      = 3'(k_q - 4'd1);
    // Unused upper shreg bits stay zero, so the reduction covers data bits only.
    assign par_calc     = (^shreg_q) ^ PARITY_ODD;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (edge_det) state_d = StStart;
            StStart:    if (is_vote) state_d = vote ? StIdle : StData;
            StData:     if (is_vote && last_data) state_d = PARITY_EN ? StParity : StStop;
            StParity:   if (is_vote) state_d = StStop;
            StStop:     if (is_vote) state_d = rxs ? StIdle : StWaitIdle;
            StWaitIdle: if (rxs) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Output logic: outcome is decided on the stop vote and registered, so the
    // strobes appear one cycle after the vote.
    always_comb begin
        data_d       = data_q;
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        brk_d        = 1'b0;
        overrun_d    = 1'b0;
        if (state_q == StStop && is_vote) begin
            if (vote) begin
                if (perr_q) begin
                    parity_err_d = 1'b1;
                end else if (rx_bus.fifo_full) begin
                    overrun_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    data_d  = shreg_q;
                end
            end else begin
                frame_err_d = 1'b1;
                brk_d       = zero_q;
            end
        end
    end

    // Datapath: synchroniser, bit timing, sampling and shift register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q       <= '1;
            rxs_prev_q   <= 1'b1;
            cnt_q        <= '0;
            n_q          <= 16'd4;
            k_q          <= '0;
            s1_q         <= 1'b1;
            s2_q         <= 1'b1;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            zero_q       <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            brk_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rxs_prev_q   <= rxs;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            brk_q        <= brk_d;
            overrun_q    <= overrun_d;
            if (state_q == StIdle) begin
                if (edge_det) begin
                    // Edge cycle counts as cnt=0, so the next cycle is cnt=1.
                    cnt_q   <= 16'd1;
                    n_q     <= baud_clamped;
                    k_q     <= '0;
                    shreg_q <= '0;
                    perr_q  <= 1'b0;
                    zero_q  <= 1'b1;
                end
            end else begin
                if (cnt_q == n_q - 16'd1) begin
                    cnt_q <= '0;
                    k_q   <= k_q + 4'd1;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
                if (is_s1) s1_q <= rxs;
                if (is_s2) s2_q <= rxs;
                if (is_vote && state_q == StData) begin
                    shreg_q[bit_idx] <= vote;
                    zero_q           <= zero_q & ~vote;
                end
                if (is_vote && state_q == StParity) begin
                    perr_q <= vote ^ par_calc;
                    zero_q <= zero_q & ~vote;
                end
            end
        end
    end

    assign busy_o            = (state_q != StIdle);
    assign rx_bus.data       = data_q;
    assign rx_bus.valid      = valid_q;
    assign rx_bus.frame_err  = frame_err_q;
    assign rx_bus.parity_err = parity_err_q;
    assign rx_bus.brk        = brk_q;
    assign rx_bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: an 8N1 instance (A, 2-stage sync) and an 8E1
// instance (B, 3-stage sync). Strobes are logged on the falling edge and compared
// against a frame-level outcome/latency model.
module tb_uart_rx_oversample;

    localparam int SYNC_A = 2;
    localparam int SYNC_B = 3;

    localparam logic [4:0] K_VALID = 5'b00001;
    localparam logic [4:0] K_FERR  = 5'b00010;
    localparam logic [4:0] K_PERR  = 5'b00100;
    localparam logic [4:0] K_OVR   = 5'b01000;
    localparam logic [4:0] K_BRK   = 5'b10000;

    typedef struct {
        int         cyc;
        logic [4:0] kind;
        logic [7:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [15:0] baud_a, baud_b;
    logic        rx_a, rx_b;
    logic        busy_a, busy_b;
    logic [4:0]  kind_a, kind_b;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  qa[$];
    ev_t  qb[$];
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;

    uart_rx_oversample_if bus_a ();
    uart_rx_oversample_if bus_b ();

    uart_rx_oversample #(
        .SYNC_STAGES (SYNC_A), .DATA_BITS (8), .PARITY_EN (1'b0), .PARITY_ODD (1'b0)
    ) dut_a (
        .clk_i (clk), .rst_ni (rst_ni), .baud_div_i (baud_a), .rx_i (rx_a),
        .busy_o (busy_a), .rx_bus (bus_a.master)
    );

    uart_rx_oversample #(
        .SYNC_STAGES (SYNC_B), .DATA_BITS (8), .PARITY_EN (1'b1), .PARITY_ODD (1'b0)
    ) dut_b (
        .clk_i (clk), .rst_ni (rst_ni), .baud_div_i (baud_b), .rx_i (rx_b),
        .busy_o (busy_b), .rx_bus (bus_b.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign kind_a = {bus_a.brk, bus_a.overrun, bus_a.parity_err, bus_a.frame_err, bus_a.valid};
    assign kind_b = {bus_b.brk, bus_b.overrun, bus_b.parity_err, bus_b.frame_err, bus_b.valid};

    always @(negedge clk) begin
        if (kind_a != 5'b0) qa.push_back('{cyc, kind_a, bus_a.data});
        if (kind_b != 5'b0) qb.push_back('{cyc, kind_b, bus_b.data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame-level outcome from the received bits.
    function automatic logic [4:0] model_kind(input logic [7:0] d, input bit pe,
                                              input bit par_bit, input bit stop,
                                              input bit full);
        if (!stop) return (d == 8'h00 && (!pe || !par_bit)) ? (K_FERR | K_BRK) : K_FERR;
        if (pe && (par_bit != (^d))) return K_PERR;
        if (full) return K_OVR;
        return K_VALID;
    endfunction

    // Drives one frame; rst_at >= 0 pulses reset on that cycle after the synced edge.
    task automatic send_frame(input bit which, input logic [7:0] d, input bit par_bit,
                              input bit stop, input logic [15:0] n_raw, input int rst_at,
                              output int fall);
        logic [10:0] bits;
        int          nb, n_eff, sync;
        bit          aborted;
        n_eff   = (n_raw < 16'd4) ? 4 : int'(n_raw);
        sync    = which ? SYNC_B : SYNC_A;
        nb      = which ? 11 : 10;
        bits    = which ? {stop, par_bit, d, 1'b0} : {1'b1, stop, d, 1'b0};
        aborted = 1'b0;
        fall    = 0;
        if (which) baud_b = n_raw; else baud_a = n_raw;
        for (int i = 0; i < nb && !aborted; i++) begin
            for (int j = 0; j < n_eff && !aborted; j++) begin
                tick(1);
                if (i == 0 && j == 0) fall = cyc;
                if (which) rx_b = bits[i]; else rx_a = bits[i];
                // Divider changes after the start bit must not disturb the frame.
                if (i == 1 && j == 0) begin
                    if (which) baud_b = 16'($urandom); else baud_a = 16'($urandom);
                end
                if (rst_at >= 0 && cyc == fall + sync + rst_at) begin
                    rst_ni = 1'b0;
                    tick(1);
                    rst_ni = 1'b1;
                    rx_a   = 1'b1;
                    rx_b   = 1'b1;
                    last_a = 8'h00;
                    last_b = 8'h00;
                    check("rst.busy", {31'b0, busy_a}, 32'd0);
                    check("rst.strobes", {27'b0, kind_a}, 32'd0);
                    check("rst.data", {24'b0, bus_a.data}, 32'd0);
                    aborted = 1'b1;
                end
            end
        end
    endtask

    task automatic check_frame(input bit which, input string tag, input logic [7:0] d,
                               input bit par_bit, input bit stop, input bit full,
                               input int fall, input logic [15:0] n_raw);
        ev_t        ev;
        int         cnt, n_eff, sync, exp_cyc;
        logic [4:0] k;
        logic [7:0] exp_data;
        n_eff   = (n_raw < 16'd4) ? 4 : int'(n_raw);
        sync    = which ? SYNC_B : SYNC_A;
        k       = model_kind(d, which, par_bit, stop, full);
        exp_cyc = fall + sync + n_eff / 2 + 1 + (1 + 8 + int'(which)) * n_eff + 1;
        if (k == K_VALID) begin
            exp_data = d;
            if (which) last_b = d; else last_a = d;
        end else begin
            exp_data = which ? last_b : last_a;
        end
        ev = '{0, 5'b0, 8'h00};
        if (which) begin
            cnt = qb.size();
            if (cnt > 0) ev = qb[0];
            qb.delete();
        end else begin
            cnt = qa.size();
            if (cnt > 0) ev = qa[0];
            qa.delete();
        end
        check({tag, ".count"}, cnt, 32'd1);
        if (cnt > 0) begin
            check({tag, ".cycle"}, ev.cyc, exp_cyc);
            check({tag, ".kind"}, {27'b0, ev.kind}, {27'b0, k});
            check({tag, ".data"}, {24'b0, ev.data}, {24'b0, exp_data});
        end
    endtask

    initial begin
        int          f, f2, r;
        logic [7:0]  d;
        logic [15:0] nraw;
        bit          which, stop, full, par;

        rst_ni = 1'b0;
        rx_a = 1'b1; rx_b = 1'b1;
        baud_a = 16'd16; baud_b = 16'd16;
        bus_a.fifo_full = 1'b0; bus_b.fifo_full = 1'b0;
        tick(3);
        check("reset.busy_a", {31'b0, busy_a}, 32'd0);
        check("reset.busy_b", {31'b0, busy_b}, 32'd0);
        check("reset.strobes_a", {27'b0, kind_a}, 32'd0);
        check("reset.data_a", {24'b0, bus_a.data}, 32'd0);
        check("reset.data_b", {24'b0, bus_b.data}, 32'd0);
        rst_ni = 1'b1;
        tick(5);
        qa.delete(); qb.delete();

        // 8N1 0xA5 at N=16: strobe at cycle 154 after the synced edge.
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 16'd16, -1, f);
        tick(40);
        if (qa.size() > 0) check("a5.latency", qa[0].cyc - (f + SYNC_A), 32'd154);
        check_frame(1'b0, "a5", 8'hA5, 1'b0, 1'b1, 1'b0, f, 16'd16);

        // Back-to-back 0x00 then 0xFF with no idle gap.
        send_frame(1'b0, 8'h00, 1'b0, 1'b1, 16'd16, -1, f);
        send_frame(1'b0, 8'hFF, 1'b0, 1'b1, 16'd16, -1, f2);
        tick(40);
        check("b2b.count", qa.size(), 32'd2);
        if (qa.size() == 2) begin
            check("b2b.spacing", qa[1].cyc - qa[0].cyc, 32'd160);
            check("b2b.first", {24'b0, qa[0].data}, 32'h00);
            check("b2b.second", {24'b0, qa[1].data}, 32'hFF);
            check("b2b.kind", {27'b0, qa[1].kind}, {27'b0, K_VALID});
        end
        qa.delete();
        last_a = 8'hFF;

        // 4-cycle glitch: false start, busy drops right after the vote cycle.
        baud_a = 16'd16;
        tick(1); rx_a = 1'b0; f = cyc;
        tick(4); rx_a = 1'b1;
        tick(7);
        check("glitch.busy_at_vote", {31'b0, busy_a}, 32'd1);
        tick(1);
        check("glitch.busy_after", {31'b0, busy_a}, 32'd0);
        tick(30);
        check("glitch.nostrobe", qa.size(), 32'd0);
        qa.delete();

        // Stop bit low: frame error only.
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 16'd16, -1, f);
        tick(1); rx_a = 1'b1;
        tick(40);
        check_frame(1'b0, "ferr", 8'h3C, 1'b0, 1'b0, 1'b0, f, 16'd16);

        // Break: rx low for 30 bit times.
        baud_a = 16'd16;
        tick(1); rx_a = 1'b0; f = cyc;
        tick(30 * 16 - 1);
        check("brk.busy_hold", {31'b0, busy_a}, 32'd1);
        tick(1); rx_a = 1'b1;
        tick(SYNC_A);
        check("brk.busy_last", {31'b0, busy_a}, 32'd1);
        tick(1);
        check("brk.busy_release", {31'b0, busy_a}, 32'd0);
        check_frame(1'b0, "brk", 8'h00, 1'b0, 1'b0, 1'b0, f, 16'd16);

        // Even parity on B: 0x07 needs parity bit 1.
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 16'd16, -1, f);
        tick(40);
        check_frame(1'b1, "par.ok", 8'h07, 1'b1, 1'b1, 1'b0, f, 16'd16);
        send_frame(1'b1, 8'h07, 1'b0, 1'b1, 16'd16, -1, f);
        tick(40);
        check_frame(1'b1, "par.bad", 8'h07, 1'b0, 1'b1, 1'b0, f, 16'd16);

        // Overrun: FIFO full, data_o keeps 0xFF.
        bus_a.fifo_full = 1'b1;
        send_frame(1'b0, 8'h55, 1'b0, 1'b1, 16'd16, -1, f);
        tick(40);
        bus_a.fifo_full = 1'b0;
        check_frame(1'b0, "ovr", 8'h55, 1'b0, 1'b1, 1'b1, f, 16'd16);

        // Reset at cycle 60 of a frame, then a clean frame.
        send_frame(1'b0, 8'h5A, 1'b0, 1'b1, 16'd16, 60, f);
        tick(250);
        check("rst.nostrobe", qa.size(), 32'd0);
        qa.delete(); qb.delete();
        send_frame(1'b0, 8'hC3, 1'b0, 1'b1, 16'd16, -1, f);
        tick(40);
        check_frame(1'b0, "post_rst", 8'hC3, 1'b0, 1'b1, 1'b0, f, 16'd16);

        // Randomised frames on both instances, including clamped dividers.
        for (int t = 0; t < 16; t++) begin
            which = 1'($urandom_range(0, 1));
            d     = 8'($urandom);
            nraw  = 16'($urandom_range(0, 24));
            stop  = ($urandom_range(0, 3) != 0);
            full  = ($urandom_range(0, 3) == 0);
            par   = (^d) ^ ($urandom_range(0, 3) == 0);
            if (which) bus_b.fifo_full = full; else bus_a.fifo_full = full;
            send_frame(which, d, par, stop, nraw, -1, f);
            tick(1);
            rx_a = 1'b1; rx_b = 1'b1;
            tick(60);
            bus_a.fifo_full = 1'b0; bus_b.fifo_full = 1'b0;
            check_frame(which, "rand", d, par, stop, full, f, nraw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
UART receive front end that turns the asynchronous rx pin into byte-write strobes for the rx FIFO of the wishbone UART. It synchronises the pin and detects the start edge, then samples each bit at mid-period with a 3-sample majority vote. It deserialises LSB-first with optional parity and reports framing, parity, break and overrun events as single-cycle strobes. It sits directly upstream of the rx FIFO write port (din/wr_en/full).

Parameters:
SYNC_STAGES, 2, flops in rx input synchroniser (legal 2..4)
DATA_BITS, 8, data bits per frame (legal 5..8); data_o upper bits zero-filled
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0

Ports:
clk_i  in  1  system clock; the single clock of the block
rst_ni  in  1  reset, synchronous, active-low
baud_div_i  in  16  clocks per bit N; values <4 treated as 4; captured at start-edge
rx_i  in  1  asynchronous serial input, idle high
fifo_full_i  in  1  rx FIFO full flag
data_o  out  8  received byte, held stable from valid_o until next valid_o
valid_o  out  1  1-cycle write strobe to rx FIFO (wr_en)
frame_err_o  out  1  1-cycle strobe, stop bit sampled low
parity_err_o  out  1  1-cycle strobe, parity mismatch
break_o  out  1  1-cycle strobe, all data, parity and stop bits low
overrun_o  out  1  1-cycle strobe, good byte dropped because fifo_full_i=1
busy_o  out  1  high from start-edge until return to IDLE

Behaviour:
- Reset (rst_ni=0 at a clock edge): FSM to IDLE; all outputs 0; data_o=0; synchroniser flops set to 1 (idle). Reset mid-frame aborts the frame with no strobes.
- rxs = output of the SYNC_STAGES synchroniser. Edge = rxs low while previous rxs high.
- Counters: bit counter cnt 0..N-1; half = N>>1; bit index k (start=0, data 1..DATA_BITS, parity, stop).
- Vote: samples at cnt = half-1, half and half+1; 2-of-3 majority decides the bit on cycle cnt=half+1.
- FSM states:
  - IDLE: wait for Edge. The edge cycle is cycle 0 (cnt=0) and N is latched then. Go to START.
  - START: at vote, bit=1 -> false start, back to IDLE with no strobes; bit=0 -> DATA.
  - DATA: shift votes LSB-first, DATA_BITS bits. Then go to PARITY if PARITY_EN, else STOP.
  - PARITY: compare the vote with computed parity; store the mismatch.
  - STOP: decide the outcome one cycle after the stop vote (see outcomes below).
  - WAIT_IDLE: stay until rxs=1, then go to IDLE. Prevents re-triggering inside a break.
- Stop-bit outcomes:
  - stop=1, no parity error, fifo_full_i=0: data_o updated, valid_o=1.
  - stop=1, no parity error, fifo_full_i=1: overrun_o=1; data_o not updated; no valid_o.
  - stop=1 with parity error: parity_err_o=1; no valid_o.
  - stop=0: frame_err_o=1; no valid_o. If all data/parity bits were also 0, break_o=1 in the same cycle as frame_err_o.
  - After any outcome, go to WAIT_IDLE if rxs=0, else IDLE.
- Latency: valid_o asserts at cycle half+1+(1+DATA_BITS+PARITY_EN)*N+1 after the edge cycle. For N=16, 8N1 this is cycle 154.
- Back-to-back: an Edge is accepted on the cycle after returning to IDLE; no bits are lost at 0% baud error.
- baud_div_i changes mid-frame have no effect until the next Edge.
- At most one strobe type per frame, except frame_err_o+break_o together.
- busy_o: 1 in all states except IDLE.
- Arithmetic: cnt is 16 bits wide; the clamp to 4 guarantees half-1 >= 1.

Test Plan:
- Reset, baud_div_i=16, 8N1, send 0xA5 -> exactly one valid_o with data_o=0xA5 at cycle 154 after synced edge; no error strobes.
- Two back-to-back frames 0x00 then 0xFF, no idle gap -> two valid_o strobes 160 cycles apart, data 0x00 then 0xFF.
- 4-clock low glitch on rx_i, N=16 -> false start, no strobes, busy_o drops after the vote.
- Frame 0x3C with stop bit forced low -> frame_err_o only. Then rx held low for 30 bit times -> frame_err_o+break_o once, busy_o held in WAIT_IDLE until rx high.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity 1 -> valid_o, data 0x07. Same byte with parity 0 -> parity_err_o, no valid_o.
- fifo_full_i=1 during 0x55 -> overrun_o, data_o keeps previous value. Also assert rst_ni=0 at cycle 60 of a frame -> all outputs 0 next cycle, no strobes, next frame received correctly.
